// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  typedef enum logic {S_CLEAR, S_RUN} rf_state_t;

  // Address width for a register count, never less than one bit.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for issue hazard detection, with busy lookup per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int NWRITE  = 1,
  parameter int NREAD   = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = clog2_safe(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_run,
  input  logic                 i_iss_valid,
  input  logic [AW-1:0]        i_iss_addr,
  input  logic [NWRITE-1:0]    i_we,
  input  logic [NWRITE*AW-1:0] i_wa,
  input  logic [NREAD*AW-1:0]  i_ra,
  input  logic [NREAD-1:0]     i_bypass,
  output logic [NREAD-1:0]     o_busy
);

  localparam bit ZR0 = (ZERO_R0 != 0);

  logic [DEPTH-1:0] r_pend;

  // NOTE: sequential state uses non-blocking assignments only; the later
  // assignment in the block wins, which gives issue priority over write clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else if (i_run) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (i_we[j]) r_pend[i_wa[j*AW +: AW]] <= 1'b0;
      end
      if (i_iss_valid) r_pend[i_iss_addr] <= 1'b1;
      if (ZR0) r_pend[0] <= 1'b0;
    end
  end

  // A read that is being bypassed this cycle already sees the new value.
  always_comb begin
    o_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      o_busy[i] = i_run & r_pend[i_ra[i*AW +: AW]] & ~i_bypass[i];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass,
// power-up clear sequencer and pending-register scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 32,
  parameter int NREAD   = 2,
  parameter int NWRITE  = 1,
  parameter int ZERO_R0 = 1,
  localparam int AW     = clog2_safe(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*XLEN-1:0]  rd,
  output logic [NREAD-1:0]       rbusy,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wa,
  input  logic [NWRITE*XLEN-1:0] wd,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_addr,
  output logic                   ready
);

  localparam bit ZR0 = (ZERO_R0 != 0);

  rf_state_t        r_state;
  rf_state_t        w_state_next;
  logic [AW-1:0]    r_clr_cnt;
  logic [XLEN-1:0]  r_rf [DEPTH];

  logic             w_run;
  logic [NWRITE-1:0] w_we_eff;
  logic [AW-1:0]    w_raddr  [NREAD];
  logic [XLEN-1:0]  w_rdata  [NREAD];
  logic [NREAD-1:0] w_bypass;

  assign w_run = (r_state == S_RUN);
  assign ready = w_run;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == AW'(DEPTH - 1)) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_clr_cnt <= '0;
    else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + AW'(1);
  end

  // Writes only take effect in S_RUN; with ZERO_R0 the address-0 write is dropped.
  always_comb begin
    w_we_eff = '0;
    for (int j = 0; j < NWRITE; j++) begin
      w_we_eff[j] = we[j] & w_run & ~(ZR0 && (wa[j*AW +: AW] == '0));
    end
  end

  // NOTE: the array has no reset; the clear sequencer zeroes it one entry per
  // cycle so it maps onto plain RAM/flop arrays without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_rf[r_clr_cnt] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (w_we_eff[j]) r_rf[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  // Higher write ports are scanned later, so they win both the bypass and the array write.
  always_comb begin
    rd       = '0;
    w_bypass = '0;
    for (int i = 0; i < NREAD; i++) begin
      w_raddr[i] = ra[i*AW +: AW];
      w_rdata[i] = r_rf[w_raddr[i]];
      for (int j = 0; j < NWRITE; j++) begin
        if (w_we_eff[j] && (wa[j*AW +: AW] == w_raddr[i])) begin
          w_rdata[i]  = wd[j*XLEN +: XLEN];
          w_bypass[i] = 1'b1;
        end
      end
      if (!w_run || (ZR0 && (w_raddr[i] == '0))) w_rdata[i] = '0;
      rd[i*XLEN +: XLEN] = w_rdata[i];
    end
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .NWRITE  (NWRITE),
    .NREAD   (NREAD),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_run       (w_run),
    .i_iss_valid (iss_valid),
    .i_iss_addr  (iss_addr),
    .i_we        (w_we_eff),
    .i_wa        (wa),
    .i_ra        (ra),
    .i_bypass    (w_bypass),
    .o_busy      (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (XLEN=32, DEPTH=32, NREAD=2, NWRITE=2).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        ready;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;

  regfile_mp #(
    .XLEN    (32),
    .DEPTH   (32),
    .NREAD   (2),
    .NWRITE  (2),
    .ZERO_R0 (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ra        (ra),
    .rd        (rd),
    .rbusy     (rbusy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = 2'b00;
    iss_valid = 1'b0;
  endtask

  // Wait for ready with a cycle bound; optionally attempt a write and issue mid-clear.
  task automatic wait_ready(input bit inject, output int n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      if (inject && n == 20) begin
        we        = 2'b01;
        wa[4:0]   = 5'd1;
        wd[31:0]  = 32'h0000_00FF;
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        #3;
        check("clr_write_no_bypass", rd[31:0], 32'h0);
        check("clr_write_no_busy", 32'(rbusy[0]), 32'h0);
      end
      step();
      idle();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ra = '0; we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0;
    step();
    step();
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_rbusy", 32'(rbusy), 32'h0);
    check("reset_rd", rd[31:0], 32'h0);
    rst = 1'b0;
    wait_ready(1'b0, cycles);
    check("clear_len", 32'(cycles), 32'd32);
    check("ready_up", 32'(ready), 32'h1);

    for (int a = 0; a < 32; a++) begin
      ra[4:0] = 5'(a);
      @(negedge clk);
      check("clr_zero", rd[31:0], 32'h0);
    end
    step();

    // Write with same-cycle bypass, then read back from the array.
    we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEAD_BEEF; ra[4:0] = 5'd5;
    @(negedge clk);
    check("bypass_rd", rd[31:0], 32'hDEAD_BEEF);
    check("bypass_busy", 32'(rbusy[0]), 32'h0);
    step(); idle();
    @(negedge clk);
    check("array_rd", rd[31:0], 32'hDEAD_BEEF);
    step();

    // Register 0 ignores writes and issues.
    we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'h0000_1234;
    iss_valid = 1'b1; iss_addr = 5'd0; ra[4:0] = 5'd0;
    @(negedge clk);
    check("r0_rd_same", rd[31:0], 32'h0);
    check("r0_busy_same", 32'(rbusy[0]), 32'h0);
    step(); idle();
    @(negedge clk);
    check("r0_rd_after", rd[31:0], 32'h0);
    check("r0_busy_after", 32'(rbusy[0]), 32'h0);
    step();

    // Two write ports hit the same address: port 1 wins.
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h0000_0002, 32'h0000_0001}; ra[9:5] = 5'd7;
    @(negedge clk);
    check("conflict_same", rd[63:32], 32'h0000_0002);
    step(); idle();
    @(negedge clk);
    check("conflict_after", rd[63:32], 32'h0000_0002);
    step();

    // Scoreboard set, set-beats-clear, clear, and bypass masking.
    iss_valid = 1'b1; iss_addr = 5'd9; ra = {5'd9, 5'd9};
    @(negedge clk);
    check("sb_not_yet", 32'(rbusy), 32'h0);
    step(); idle();
    @(negedge clk);
    check("sb_set", 32'(rbusy), 32'h3);
    step();
    we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h0000_00AA; iss_valid = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    check("sb_wr_iss_bypass", 32'(rbusy), 32'h0);
    step(); idle();
    @(negedge clk);
    check("sb_set_wins", 32'(rbusy), 32'h3);
    step();
    we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h0000_00BB;
    @(negedge clk);
    check("sb_clr_bypass_busy", 32'(rbusy), 32'h0);
    check("sb_clr_bypass_rd", rd[63:32], 32'h0000_00BB);
    step(); idle();
    @(negedge clk);
    check("sb_cleared", 32'(rbusy), 32'h0);
    check("sb_cleared_rd", rd[31:0], 32'h0000_00BB);
    step();

    // Fill r1..r3, issue r4, then reset in the middle of operation.
    we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'h0000_0022, 32'h0000_0011};
    step();
    we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'h0000_0033; iss_valid = 1'b1; iss_addr = 5'd4;
    step(); idle();
    ra = {5'd4, 5'd3};
    @(negedge clk);
    check("fill_r3", rd[31:0], 32'h0000_0033);
    check("fill_busy4", 32'(rbusy[1]), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ra = {5'd4, 5'd1};
    @(negedge clk);
    check("mid_ready", 32'(ready), 32'h0);
    check("mid_rd", rd[31:0], 32'h0);
    check("mid_busy", 32'(rbusy), 32'h0);
    wait_ready(1'b1, cycles);
    check("mid_clear_len", 32'(cycles), 32'd32);
    for (int a = 1; a <= 3; a++) begin
      ra[4:0] = 5'(a);
      @(negedge clk);
      check("mid_cleared", rd[31:0], 32'h0);
    end
    ra = {5'd5, 5'd4};
    @(negedge clk);
    check("mid_busy_after", 32'(rbusy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
